// File: rtl/celda_axil_slave.sv
`default_nettype none
// ============================================================================
// Module   : celda_axil_slave
// Brief    : AXI4-Lite slave exposing four 32-bit read/write registers with
//            independent write and read state machines.
// Revision : 1.0 - initial release
// ============================================================================
module celda_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int c_STRB_W = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  wstate_t                       wstate_q;
  rstate_t                       rstate_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];

  logic                          awready_q, wready_q, bvalid_q;
  logic                          aw_done_q, w_done_q;
  logic [1:0]                    awidx_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [c_STRB_W-1:0]           wstrb_q;

  logic                          arready_q, rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  logic                          aw_hs, w_hs, aw_have_d, w_have_d;
  logic [1:0]                    widx_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_d;
  logic [c_STRB_W-1:0]           wstrb_d;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Merge this cycle's handshakes with the already-latched halves of the write.
  always_comb begin
    aw_hs     = S_AXI_AWVALID & awready_q;
    w_hs      = S_AXI_WVALID & wready_q;
    aw_have_d = aw_done_q | aw_hs;
    w_have_d  = w_done_q | w_hs;
    widx_d    = aw_hs ? S_AXI_AWADDR[3:2] : awidx_q;
    wdata_d   = w_hs ? S_AXI_WDATA : wdata_q;
    wstrb_d   = w_hs ? S_AXI_WSTRB : wstrb_q;
  end

  // Write FSM: collect AW and W in any order, commit bytes, hold B until taken.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (aw_have_d && w_have_d) begin
            for (int b = 0; b < c_STRB_W; b++) begin
              if (wstrb_d[b]) regs_q[widx_d][8*b +: 8] <= wdata_d[8*b +: 8];
            end
            bvalid_q  <= 1'b1;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wstate_q  <= W_RESP;
          end else begin
            aw_done_q <= aw_have_d;
            w_done_q  <= w_have_d;
            awidx_q   <= widx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= ~aw_have_d;
            wready_q  <= ~w_have_d;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Read FSM: snapshot the addressed register on AR, hold R until taken.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (S_AXI_ARVALID && arready_q) begin
            rdata_q   <= regs_q[S_AXI_ARADDR[3:2]];
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rstate_q  <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_celda_axil_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_celda_axil_slave
// Brief    : Self-checking bench for celda_axil_slave: vector table, directed
//            corner sequences and randomized traffic against a register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_celda_axil_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [3:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [3:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [4];

  celda_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model of a strobed register write: replace enabled bytes only.
  task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    for (int k = 0; k < 4; k++) if (s[k]) m = m | (32'hFF << (8 * k));
    model[a[3:2]] = (model[a[3:2]] & ~m) | (d & m);
  endtask

  // Full write: AW asserted after awd cycles, W after wd cycles, then B.
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd, output int blat);
    bit awdone, wdone, ah, wh, got;
    int cyc;
    awdone = 0; wdone = 0; cyc = 0; blat = -1; got = 0;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    while (!(awdone && wdone) && cyc < 50) begin
      S_AXI_AWVALID = !awdone && (cyc >= awd);
      S_AXI_WVALID  = !wdone && (cyc >= wd);
      @(negedge ACLK);
      ah = S_AXI_AWVALID && S_AXI_AWREADY;
      wh = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      awdone = awdone | ah; wdone = wdone | wh; cyc++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    if (!(awdone && wdone)) begin
      chk("wr_handshake_timeout", 32'(cyc), 32'(awd > wd ? awd : wd));
      return;
    end
    model_write(a, d, s);
    S_AXI_BREADY = 1'b1;
    cyc = 0;
    while (!got && cyc < 50) begin
      @(negedge ACLK);
      if (S_AXI_BVALID) begin
        got = 1; blat = cyc;
        chk("bresp", 32'(S_AXI_BRESP), 32'h0);
      end
      @(posedge ACLK); #1;
      cyc++;
    end
    S_AXI_BREADY = 1'b0;
    if (!got) chk("b_timeout", 32'(S_AXI_BVALID), 32'h1);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output int rlat);
    bit h, got;
    int cyc;
    h = 0; got = 0; cyc = 0; d = 'x; rlat = -1;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    while (!h && cyc < 50) begin
      @(negedge ACLK);
      h = S_AXI_ARREADY;
      @(posedge ACLK); #1;
      cyc++;
    end
    S_AXI_ARVALID = 1'b0;
    if (!h) begin
      chk("ar_timeout", 32'(S_AXI_ARREADY), 32'h1);
      return;
    end
    S_AXI_RREADY = 1'b1;
    cyc = 0;
    while (!got && cyc < 50) begin
      @(negedge ACLK);
      if (S_AXI_RVALID) begin
        got = 1; d = S_AXI_RDATA; rlat = cyc;
        chk("rresp", 32'(S_AXI_RRESP), 32'h0);
      end
      @(posedge ACLK); #1;
      cyc++;
    end
    S_AXI_RREADY = 1'b0;
    if (!got) chk("r_timeout", 32'(S_AXI_RVALID), 32'h1);
  endtask

  task automatic check_outputs_reset(input string tag);
    chk({tag, "_awready"}, 32'(S_AXI_AWREADY), 32'h0);
    chk({tag, "_wready"},  32'(S_AXI_WREADY),  32'h0);
    chk({tag, "_arready"}, 32'(S_AXI_ARREADY), 32'h0);
    chk({tag, "_bvalid"},  32'(S_AXI_BVALID),  32'h0);
    chk({tag, "_rvalid"},  32'(S_AXI_RVALID),  32'h0);
    chk({tag, "_rdata"},   S_AXI_RDATA,        32'h0);
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t tbl [9];
    logic [31:0] rd;
    int lat, nb, naw;

    tbl[0] = '{4'h0, 32'h1, 4'hF, 32'h1};
    tbl[1] = '{4'h4, 32'h2, 4'hF, 32'h2};
    tbl[2] = '{4'h8, 32'h3, 4'hF, 32'h3};
    tbl[3] = '{4'hC, 32'h4, 4'hF, 32'h4};
    tbl[4] = '{4'h5, 32'h11223344, 4'hF, 32'h11223344};
    tbl[5] = '{4'h4, 32'hFFFFFFFF, 4'h2, 32'h1122FF44};
    tbl[6] = '{4'h0, 32'hDEADBEEF, 4'h0, 32'h00000001};
    tbl[7] = '{4'h3, 32'hAABBCCDD, 4'h9, 32'hAA0000DD};
    tbl[8] = '{4'hE, 32'h12345678, 4'h6, 32'h00345604};
    for (int i = 0; i < 4; i++) model[i] = 32'h0;

    // Reset behaviour and ready rise on first edge after release.
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_outputs_reset("in_reset");
    ARESETN = 1'b1;
    #1;
    chk("pre_edge_awready", 32'(S_AXI_AWREADY), 32'h0);
    @(posedge ACLK); #1;
    chk("post_rst_awready", 32'(S_AXI_AWREADY), 32'h1);
    chk("post_rst_wready",  32'(S_AXI_WREADY),  32'h1);
    chk("post_rst_arready", 32'(S_AXI_ARREADY), 32'h1);

    // Vector table: write four registers, read them back, then strobe rows.
    for (int i = 0; i < 4; i++) begin
      axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, lat);
      chk("b_latency", 32'(lat), 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(tbl[i].addr, rd, lat);
      chk($sformatf("tbl_rd%0d", i), rd, tbl[i].exp);
      chk("r_latency", 32'(lat), 32'h0);
    end
    for (int i = 4; i < 9; i++) begin
      axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, i % 3, (i + 1) % 3, lat);
      axi_read(tbl[i].addr, rd, lat);
      chk($sformatf("tbl_rd%0d", i), rd, tbl[i].exp);
    end

    // AW three cycles ahead of W; register must not change until W arrives.
    S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    chk("early_aw_awready", 32'(S_AXI_AWREADY), 32'h1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    @(negedge ACLK);
    chk("aw_latched_awready", 32'(S_AXI_AWREADY), 32'h0);
    chk("aw_latched_wready",  32'(S_AXI_WREADY),  32'h1);
    @(posedge ACLK); #1;
    axi_read(4'h8, rd, lat);
    chk("aw_only_no_write", rd, model[2]);
    chk("aw_only_bvalid", 32'(S_AXI_BVALID), 32'h0);
    S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    chk("late_w_wready", 32'(S_AXI_WREADY), 32'h1);
    @(posedge ACLK); #1;
    S_AXI_WVALID = 1'b0;
    model_write(4'h8, 32'hA5A5A5A5, 4'hF);
    @(negedge ACLK);
    chk("late_w_bvalid", 32'(S_AXI_BVALID), 32'h1);
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    axi_read(4'h8, rd, lat);
    chk("late_w_readback", rd, 32'hA5A5A5A5);

    // BREADY held low: response held, second write blocked.
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'hCAFE0001; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    model_write(4'h0, 32'hCAFE0001, 4'hF);
    S_AXI_WDATA = 32'hBAD0BAD0;
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      chk("bstall_bvalid",  32'(S_AXI_BVALID),  32'h1);
      chk("bstall_awready", 32'(S_AXI_AWREADY), 32'h0);
      chk("bstall_wready",  32'(S_AXI_WREADY),  32'h0);
      @(posedge ACLK); #1;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    chk("bstall_release_bvalid", 32'(S_AXI_BVALID), 32'h0);
    axi_read(4'h0, rd, lat);
    chk("bstall_readback", rd, 32'hCAFE0001);

    // Same-edge write and read of one register returns the old value.
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h5EED5EED; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 4'hC;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    chk("collide_rdata",  S_AXI_RDATA, model[3]);
    chk("collide_rvalid", 32'(S_AXI_RVALID), 32'h1);
    chk("collide_bvalid", 32'(S_AXI_BVALID), 32'h1);
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    model_write(4'hC, 32'h5EED5EED, 4'hF);
    axi_read(4'hC, rd, lat);
    chk("collide_after", rd, 32'h5EED5EED);

    // Back-to-back writes with all READYs high: one every two cycles.
    nb = 0; naw = 0;
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h0B0B0B0B; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge ACLK);
      if (S_AXI_AWVALID && S_AXI_AWREADY && S_AXI_WREADY) naw++;
      if (S_AXI_BVALID) nb++;
      @(posedge ACLK); #1;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    model_write(4'h4, 32'h0B0B0B0B, 4'hF);
    chk("b2b_aw_count", 32'(naw), 32'h3);
    chk("b2b_b_count",  32'(nb),  32'h3);

    // Randomized traffic against the register model.
    for (int it = 0; it < 200; it++) begin
      logic [3:0]  ra;
      logic [31:0] rdat;
      ra = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        rdat = $urandom;
        axi_write(ra, rdat, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), lat);
      end else begin
        axi_read(ra, rd, lat);
        chk($sformatf("rand_rd_a%0h", ra), rd, model[ra[3:2]]);
      end
    end

    // Asynchronous reset while both B and R are pending.
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h77777777; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    chk("prerst_bvalid", 32'(S_AXI_BVALID), 32'h1);
    chk("prerst_rvalid", 32'(S_AXI_RVALID), 32'h1);
    #2 ARESETN = 1'b0;
    #1;
    check_outputs_reset("async_rst");
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd, lat);
      chk($sformatf("post_rst_reg%0d", i), rd, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
